// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin arbiter that time-shares one signed multiplier among NUM_REQ
// requesters. One grant per cycle, two-cycle latency from handshake to result,
// results tagged with the winning requester's index.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   en         grant enable; in-flight work drains while low
//   req_valid  per-requester request valid
//   req_a      flattened signed operand A, requester i in slice i
//   req_b      flattened signed operand B, same layout
//   req_ready  one-hot grant (combinational)
//   res_valid  result valid pulse
//   res_id     index of the requester owning res_data
//   res_data   signed product, low OUTPUT_WIDTH+1 bits (wraps, no saturation)
//   busy       any pipeline stage holds valid data
module mult_share_arbiter #(
  parameter int MULT_WORD_SIZE = 18,
  parameter int OUTPUT_WIDTH   = 2 * MULT_WORD_SIZE,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   en,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*(MULT_WORD_SIZE+1)-1:0]  req_a,
  input  logic [NUM_REQ*(MULT_WORD_SIZE+1)-1:0]  req_b,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   res_valid,
  output logic [ID_W-1:0]                        res_id,
  output logic signed [OUTPUT_WIDTH:0]           res_data,
  output logic                                   busy
);

  localparam int          OW  = MULT_WORD_SIZE + 1;
  localparam int          PW  = OUTPUT_WIDTH + 1;
  localparam int          EXT = PW - OW;
  localparam int unsigned NR  = NUM_REQ;

  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      ptr_nxt;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 hs;
  logic signed [OW-1:0] a_sel;
  logic signed [OW-1:0] b_sel;

  logic signed [OW-1:0] a_q;
  logic signed [OW-1:0] b_q;
  logic [ID_W-1:0]      id_q;
  logic                 v1;
  logic signed [PW-1:0] prod;

  // Search from ptr upward with wrap-around; first valid index wins.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
    // resetn gates the grant so req_ready stays low throughout reset.
    hs        = found & en & resetn;
    req_ready = hs ? (NUM_REQ'(1) << win) : '0;
    a_sel     = req_a[int'(win)*OW +: OW];
    b_sel     = req_b[int'(win)*OW +: OW];
    ptr_nxt   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Operands are sign-extended to the result width first; the low PW bits of
  // the product are all that is kept, which gives the wrapping behaviour.
  assign prod = $signed({{EXT{a_q[OW-1]}}, a_q}) * $signed({{EXT{b_q[OW-1]}}, b_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      v1        <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (hs) begin
        ptr  <= ptr_nxt;
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= win;
      end
      v1        <= hs;
      res_data  <= prod;
      res_id    <= id_q;
      res_valid <= v1;
    end
  end

  assign busy = v1 | res_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios followed by
// random traffic, checked against a cycle-indexed table of expected results.
module tb_mult_share_arbiter;

  localparam int N    = 4;
  localparam int MW   = 18;
  localparam int OW   = MW + 1;
  localparam int PW   = 2 * MW + 1;
  localparam int IDW  = 2;
  localparam int MAXC = 1024;

  logic              clk = 1'b0;
  logic              resetn;
  logic              en;
  logic [N-1:0]      req_valid;
  logic [N*OW-1:0]   req_a;
  logic [N*OW-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic signed [PW-1:0] res_data;
  logic              busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .MULT_WORD_SIZE(MW),
    .NUM_REQ(N)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_id(res_id),
    .res_data(res_data),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  int     opa [N];
  int     opb [N];
  // Expected output per cycle: a handshake in cycle c fills slot c+2.
  bit     ev  [MAXC];
  int     eid [MAXC];
  longint ed  [MAXC];
  int     cyc  = 0;
  int     mptr = 0;
  logic [N-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
    end
  endtask

  function automatic longint wrap37(input longint p);
    logic [63:0] v;
    v = p;
    return longint'({{27{v[36]}}, v[36:0]});
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p, input logic e, input logic r);
    if (!e || !r) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int rnd_op();
    int v;
    case ($urandom_range(0, 7))
      0:       return -262144;
      1:       return 262143;
      default: begin
        v = int'($urandom_range(0, 524287));
        return (v >= 262144) ? v - 524288 : v;
      end
    endcase
  endfunction

  task automatic drive();
    logic [OW-1:0] ta;
    logic [OW-1:0] tb;
    for (int i = 0; i < N; i++) begin
      ta = OW'(opa[i]);
      tb = OW'(opb[i]);
      req_a[i*OW +: OW] = ta;
      req_b[i*OW +: OW] = tb;
    end
  endtask

  // One clock cycle: drive, check at the falling edge, update the model,
  // then return 1 time unit after the next rising edge.
  task automatic step(input bit drop_rst);
    int w;
    drive();
    @(negedge clk);
    w = pick(req_valid, mptr, en, resetn);
    last_rdy = req_ready;
    chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
    chk("res_valid", 64'(res_valid), 64'(ev[cyc]));
    chk("busy", 64'(busy), 64'(ev[cyc] | ev[cyc+1]));
    if (ev[cyc]) begin
      chk("res_id", 64'(res_id), 64'(eid[cyc]));
      chk("res_data", 64'(res_data), 64'(ed[cyc]));
    end
    if (w >= 0) begin
      ev[cyc+2]  = 1'b1;
      eid[cyc+2] = w;
      ed[cyc+2]  = wrap37(longint'(opa[w]) * longint'(opb[w]));
      mptr       = (w + 1) % N;
    end
    if (drop_rst) begin
      #1;
      resetn    = 1'b0;
      ev[cyc+1] = 1'b0;
      ev[cyc+2] = 1'b0;
      mptr      = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC - 3);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic reset_pulse();
    resetn  = 1'b0;
    ev[cyc]   = 1'b0;
    ev[cyc+1] = 1'b0;
    mptr    = 0;
    step(0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    en        = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd_op();
      opb[i] = rnd_op();
    end

    // Reset state: no grants even with en high and all requests valid.
    step(0);
    step(0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;

    // Single requester 1: 3 * -5.
    req_valid = 4'b0010;
    opa[1] = 3;
    opb[1] = -5;
    step(0);
    chk("t1_grant", 64'(last_rdy), 64'b0010);
    req_valid = '0;
    step(0);
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_id", 64'(res_id), 64'd1);
    chk("t1_data", 64'(res_data), -64'sd15);
    step(0);
    // ptr now 2: all-valid grant must go to requester 2.
    req_valid = '1;
    step(0);
    chk("t1_ptr", 64'(last_rdy), 64'b0100);
    req_valid = '0;
    reset_pulse();

    // Rotation with a=i+1, b=10.
    for (int i = 0; i < N; i++) begin
      opa[i] = i + 1;
      opb[i] = 10;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      step(0);
      chk("rot_grant", 64'(last_rdy), 64'd1 << (k % N));
    end
    req_valid = '0;
    step(0);
    step(0);

    // Overflow corner and largest exact negative product.
    opa[0] = -262144; opb[0] = -262144;
    opa[2] = 262143;  opb[2] = -262144;
    req_valid = 4'b0001;
    step(0);
    req_valid = 4'b0100;
    step(0);
    req_valid = '0;
    chk("ovf_wrap", 64'(res_data), -64'sd68719476736);
    step(0);
    chk("ovf_exact", 64'(res_data), -64'sd68719214592);
    step(0);

    // en toggling mid-stream.
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd_op();
      opb[i] = rnd_op();
    end
    req_valid = '1;
    for (int k = 0; k < 3; k++) step(0);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(0);
      chk("en_low_grant", 64'(last_rdy), 64'd0);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) step(0);
    req_valid = '0;
    step(0);
    step(0);

    // Reset mid-flight: two grants, reset between them and their results.
    req_valid = '1;
    step(0);
    step(1);
    step(0);
    step(0);
    chk("mid_rst_data", 64'(res_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    step(0);
    chk("mid_rst_first", 64'(last_rdy), 64'b0001);

    // Sparse requests with ptr=1.
    req_valid = 4'b1001;
    step(0);
    chk("sparse_0", 64'(last_rdy), 64'b1000);
    step(0);
    chk("sparse_1", 64'(last_rdy), 64'b0001);
    step(0);
    chk("sparse_2", 64'(last_rdy), 64'b1000);
    req_valid = '0;
    step(0);
    step(0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        opa[i] = rnd_op();
        opb[i] = rnd_op();
      end
      step(0);
    end
    req_valid = '0;
    en        = 1'b1;
    for (int k = 0; k < 3; k++) step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter that time-shares one signed multiplier datapath among NUM_REQ requesters inside the welford extern. Each requester presents a signed operand pair with a valid/ready handshake. The arbiter grants at most one request per cycle, registers the operands, multiplies them, and returns the registered product tagged with the winner's index. Sustained throughput is one product per cycle with a fixed latency of 2 cycles.

## Interface
- MULT_WORD_SIZE, 18, operand magnitude width; each operand is MULT_WORD_SIZE+1 bits signed.
- OUTPUT_WIDTH, 2*MULT_WORD_SIZE, product is OUTPUT_WIDTH+1 bits signed.
- NUM_REQ, 4, number of requesters, 2..8.
- ID_W, clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; when low, no new grants are issued and in-flight work still drains.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*(MULT_WORD_SIZE+1)  flattened operand A; requester i occupies slice i.
- req_b  in  NUM_REQ*(MULT_WORD_SIZE+1)  flattened operand B; same layout as req_a.
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
- res_valid  out  1  result valid pulse.
- res_id  out  ID_W  index of the requester that owns res_data.
- res_data  out  OUTPUT_WIDTH+1  signed product.
- busy  out  1  high while any stage of the pipeline holds valid data.

## Operation
- Arbitration is combinational from req_valid, en and the round-robin pointer ptr (ID_W bits).
- The winner is the first index i with req_valid[i]=1, searching from ptr upward with wrap-around.
- req_ready has exactly one bit set (the winner) when en=1 and any req_valid is high; otherwise req_ready is all zeros.
- req_ready never asserts for a requester whose req_valid is low.
- On a completed handshake, ptr becomes (winner+1) mod NUM_REQ. Without a handshake, ptr holds.
- Stage 1 (issue) registers, on a handshake: a_q, b_q, id_q and v1=1. Without a handshake, v1=0.
- Stage 2 (result) registers: res_data = a_q*b_q, res_id = id_q, res_valid = v1.
- Results have no backpressure; the consumer must accept res_valid every cycle.
- Width rule: res_data is the low OUTPUT_WIDTH+1 bits of the exact signed product.
- The only overflowing case is (-2^MULT_WORD_SIZE)*(-2^MULT_WORD_SIZE), which wraps to -2^OUTPUT_WIDTH. The block does not saturate.
- busy = v1 | res_valid.
- Requesters must hold req_a, req_b and req_valid stable until granted. The arbiter does not require this for correctness, but it does for fairness.

## Timing
- Reset values: ptr=0, v1=0, a_q=b_q=0, id_q=0, res_valid=0, res_id=0, res_data=0, busy=0. req_ready is combinational and is 0 while resetn=0, because en is ignored during reset.
- Latency: a handshake in cycle T gives res_valid=1 in cycle T+2, with the operands sampled in cycle T.
- Throughput: one handshake per cycle. Back-to-back grants produce back-to-back results.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. The worst-case wait is NUM_REQ-1 cycles.
- Dropping en mid-stream: no grant occurs that cycle, ptr holds, and results already in flight still emerge on schedule.
- Reset asserted mid-operation: all pipeline contents are discarded immediately (asynchronously), no res_valid is produced for them, and ptr returns to 0.
- Reset release is synchronized externally; the first grant is possible on the first edge after resetn goes high.
- When only one requester is valid, it is granted every cycle regardless of ptr.

## Test plan
- Single requester, NUM_REQ=4: req_valid=0010, a=3, b=-5 at T → req_ready=0010 at T; at T+2, res_valid=1, res_id=1, res_data=-15; ptr=2.
- All four requesters valid continuously for 8 cycles, a=i+1, b=10 → grants 0,1,2,3,0,1,2,3; results 10,20,30,40 repeat, with res_id matching, 2 cycles after each grant.
- Overflow corner: a=b=-262144 → res_data=-2^36 (wrapped). Also a=262143, b=-262144 → -68719214592 (exact).
- en toggling: all requesters valid, en low for 2 cycles in the middle → no req_ready during those cycles, ptr frozen, the 2 in-flight results still appear, and rotation resumes at the frozen ptr.
- Reset mid-flight: grants in cycles T and T+1, resetn low at T+1.5 → res_valid never asserts for either request, all outputs are 0, and after release the first grant goes to index 0.
- Sparse requests: req_valid=1001 with ptr=1 → the grant order is 3, then 0, then 3.
